// File: rtl/cnn_win_sched_pkg.sv
// cnn_win_sched_pkg
//   Shared types and elaboration-time helpers for the convolution window
//   scheduler.
//   - win_state_t : scheduler FSM states
//   - win_count() : number of KxK windows in an IMG_W x IMG_H frame
//   - anchor_off(): offset from a window's top-left pixel to its
//                   bottom-right pixel
package cnn_win_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ADV,
    DONE
  } win_state_t;

  function automatic int win_count(int img_w, int img_h, int k);
    return (img_h - k + 1) * (img_w - k + 1);
  endfunction

  function automatic int anchor_off(int img_w, int k);
    return (k - 1) * img_w + (k - 1);
  endfunction

endpackage

// File: rtl/cnn_win_sched_if.sv
// cnn_win_sched_if
//   Bundles the scheduler's control inputs and its RAM-read / pixel-stream
//   outputs.
//   Inputs to the scheduler:
//     clr        synchronous frame restart pulse
//     wr_addr    count of image pixels written so far
//     core_bsy   downstream core still busy with the previous window
//   Outputs from the scheduler:
//     ram_rd     RAM read strobe
//     ram_addr   RAM read address
//     pix_vld    RAM dout valid (ram_rd delayed one cycle)
//     pix_first  with pix_vld: tap 0 of a window
//     pix_last   with pix_vld: last tap of a window
//     busy       a window is being issued or advanced
//     frame_done one-cycle pulse after the final tap of the frame
//   Modports: master = the scheduler, slave = its environment.
interface cnn_win_sched_if #(
  parameter int AW = 10
);

  logic          clr;
  logic [AW-1:0] wr_addr;
  logic          core_bsy;
  logic          ram_rd;
  logic [AW-1:0] ram_addr;
  logic          pix_vld;
  logic          pix_first;
  logic          pix_last;
  logic          busy;
  logic          frame_done;

  modport master (
    input  clr, wr_addr, core_bsy,
    output ram_rd, ram_addr, pix_vld, pix_first, pix_last, busy, frame_done
  );

  modport slave (
    output clr, wr_addr, core_bsy,
    input  ram_rd, ram_addr, pix_vld, pix_first, pix_last, busy, frame_done
  );

endinterface

// File: rtl/cnn_win_sched.sv
// cnn_win_sched
//   Walks a KxK window across a 1-bit image held in RAM, one pixel step at a
//   time, row by row. A window is started only when its bottom-right pixel
//   has been written and the core is idle; it then issues K*K row-major tap
//   reads on consecutive cycles. Pixel valid/first/last flags follow the
//   reads by one cycle to line up with the RAM's read latency.
//   Ports:
//     clk  clock
//     rst  asynchronous reset, active-high
//     bus  cnn_win_sched_if.master (clr, wr_addr, core_bsy in; RAM read and
//          pixel-stream flags out)
module cnn_win_sched
  import cnn_win_sched_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 3,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  cnn_win_sched_if.master  bus
);

  localparam int TW = (K > 1) ? $clog2(K) : 1;

  localparam logic [AW:0]   ANCHOR    = (AW+1)'(anchor_off(IMG_W, K));
  // Jump from the last tap of one window row to the first tap of the next.
  localparam logic [AW-1:0] ROW_STEP  = AW'(IMG_W - K + 1);
  // Jump of the top-left pixel when the window wraps to the next row.
  localparam logic [AW-1:0] WRAP_STEP = AW'(K);
  localparam logic [AW-1:0] COL_MAX   = AW'(IMG_W - K);
  localparam logic [AW-1:0] ROW_MAX   = AW'(IMG_H - K);
  localparam logic [TW-1:0] TAP_MAX   = TW'(K - 1);

  win_state_t    state;
  logic [AW-1:0] tl;
  logic [AW-1:0] row;
  logic [AW-1:0] col;
  logic [AW-1:0] tap_addr;
  logic [TW-1:0] tap_r;
  logic [TW-1:0] tap_c;
  logic          ram_rd_q;
  logic          pix_vld_q;
  logic          pix_first_q;
  logic          pix_last_q;
  logic          frame_done_q;

  logic avail;
  logic tap_first;
  logic tap_last;
  logic last_win;

  // One extra bit keeps tl + anchor from wrapping past wr_addr.
  assign avail     = ({1'b0, tl} + ANCHOR) < {1'b0, bus.wr_addr};
  assign tap_first = (tap_r == '0) && (tap_c == '0);
  assign tap_last  = (tap_r == TAP_MAX) && (tap_c == TAP_MAX);
  assign last_win  = (row == ROW_MAX) && (col == COL_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tl           <= '0;
      row          <= '0;
      col          <= '0;
      tap_addr     <= '0;
      tap_r        <= '0;
      tap_c        <= '0;
      ram_rd_q     <= 1'b0;
      pix_vld_q    <= 1'b0;
      pix_first_q  <= 1'b0;
      pix_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (bus.clr) begin
      // Restart wins over everything, including a read issued this cycle:
      // the pixel pipeline is flushed so that read never shows as valid.
      state        <= IDLE;
      tl           <= '0;
      row          <= '0;
      col          <= '0;
      tap_addr     <= '0;
      tap_r        <= '0;
      tap_c        <= '0;
      ram_rd_q     <= 1'b0;
      pix_vld_q    <= 1'b0;
      pix_first_q  <= 1'b0;
      pix_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pix_vld_q    <= ram_rd_q;
      pix_first_q  <= ram_rd_q && tap_first;
      pix_last_q   <= ram_rd_q && tap_last;
      frame_done_q <= 1'b0;

      case (state)
        IDLE: begin
          if (avail && !bus.core_bsy) begin
            state    <= ISSUE;
            ram_rd_q <= 1'b1;
            tap_addr <= tl;
            tap_r    <= '0;
            tap_c    <= '0;
          end
        end

        ISSUE: begin
          if (tap_last) begin
            // frame_done lands in the ADV cycle, one cycle after the
            // final read of the last window.
            ram_rd_q     <= 1'b0;
            state        <= ADV;
            frame_done_q <= last_win;
          end else if (tap_c == TAP_MAX) begin
            tap_c    <= '0;
            tap_r    <= tap_r + TW'(1);
            tap_addr <= tap_addr + ROW_STEP;
          end else begin
            tap_c    <= tap_c + TW'(1);
            tap_addr <= tap_addr + AW'(1);
          end
        end

        ADV: begin
          if (col < COL_MAX) begin
            tl    <= tl + AW'(1);
            col   <= col + AW'(1);
            state <= IDLE;
          end else if (row < ROW_MAX) begin
            tl    <= tl + WRAP_STEP;
            col   <= '0;
            row   <= row + AW'(1);
            state <= IDLE;
          end else begin
            state <= DONE;
          end
        end

        DONE: begin
          state <= DONE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_rd     = ram_rd_q;
  assign bus.ram_addr   = tap_addr;
  assign bus.pix_vld    = pix_vld_q;
  assign bus.pix_first  = pix_first_q;
  assign bus.pix_last   = pix_last_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state == ISSUE) || (state == ADV);

endmodule

// File: tb/tb_cnn_win_sched.sv
// tb_cnn_win_sched
//   Self-checking bench for cnn_win_sched at the default geometry.
//   A negedge monitor compares every read and every pixel flag against a
//   window/tap model computed from window index arithmetic; directed tables
//   cover availability gating and specific window addresses, and hand
//   sequences cover core_bsy, clr and rst in the middle of a window.
module tb_cnn_win_sched;

  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int K      = 3;
  localparam int AW     = 10;
  localparam int NCOL   = IMG_W - K + 1;
  localparam int NWIN   = (IMG_H - K + 1) * NCOL;
  localparam int NTAP   = K * K;
  localparam int ANCHOR = (K - 1) * IMG_W + (K - 1);
  localparam int NPIX   = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cnn_win_sched_if #(.AW(AW)) bus ();

  cnn_win_sched #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(string name, int got, int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Address of tap t of window w, from the frame geometry alone.
  function automatic int exp_addr(int w, int t);
    if (w >= NWIN) return -1;
    return (w / NCOL) * IMG_W + (w % NCOL) + (t / K) * IMG_W + (t % K);
  endfunction

  // ---------------- monitor / reference model ----------------
  int m_win = 0;
  int m_tap = 0;
  bit prev_rd = 0, prev_first = 0, prev_last = 0;
  int prev_wr = 0;
  bit prev_bsy = 0;
  int n_first = 0, n_vld = 0, n_fd = 0, n_rd = 0;
  int cap [NWIN][NTAP];

  always @(negedge clk) begin
    if (rst) begin
      m_win = 0; m_tap = 0;
      prev_rd = 0; prev_first = 0; prev_last = 0;
    end else begin
      check("pix_vld", int'(bus.pix_vld), int'(prev_rd));
      check("pix_first", int'(bus.pix_first), int'(prev_first));
      check("pix_last", int'(bus.pix_last), int'(prev_last));
      if (bus.pix_first) n_first++;
      if (bus.pix_vld) n_vld++;
      if (bus.frame_done) begin
        n_fd++;
        check("fd_after_last_rd", int'(prev_rd), 1);
        check("fd_all_windows", m_win, NWIN);
      end
      prev_first = 0;
      prev_last  = 0;
      if (bus.ram_rd) begin
        n_rd++;
        check("rd_addr", int'(bus.ram_addr), exp_addr(m_win, m_tap));
        if (m_tap == 0)
          check("start_avail", int'(prev_wr > exp_addr(m_win, 0) + ANCHOR && !prev_bsy), 1);
        if (m_win < NWIN) cap[m_win][m_tap] = int'(bus.ram_addr);
        prev_first = (m_tap == 0);
        prev_last  = (m_tap == NTAP - 1);
        m_tap++;
        if (m_tap == NTAP) begin m_tap = 0; m_win++; end
      end
      prev_rd = bus.ram_rd;
      if (bus.clr) begin
        m_win = 0; m_tap = 0;
        prev_rd = 0; prev_first = 0; prev_last = 0;
      end
    end
    prev_wr  = int'(bus.wr_addr);
    prev_bsy = bus.core_bsy;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic restart(int wr, bit bsy);
    bus.clr = 1'b1; bus.wr_addr = AW'(wr); bus.core_bsy = bsy;
    step(1);
    bus.clr = 1'b0;
  endtask

  typedef struct {
    int wr;
    bit bsy;
    int exp_lat;   // cycles from clr release to first ram_rd, -1 = none
  } avail_vec_t;

  typedef struct packed {
    logic [15:0]          win;
    logic [NTAP*AW-1:0]   addrs;   // tap 0 in the most significant slot
  } win_vec_t;

  avail_vec_t av [7];
  win_vec_t   wv [5];

  initial begin
    int lat, base_first, base_vld, base_fd, base_rd, cnt, found, got_bits, exp_bits;
    bus.clr = 1'b0; bus.wr_addr = '0; bus.core_bsy = 1'b0;

    av[0] = '{58, 1'b0, -1};
    av[1] = '{59, 1'b0, 1};
    av[2] = '{0, 1'b0, -1};
    av[3] = '{784, 1'b1, -1};
    av[4] = '{784, 1'b0, 1};
    av[5] = '{59, 1'b1, -1};
    av[6] = '{1023, 1'b0, 1};

    wv[0] = '{16'd0,   {10'd0, 10'd1, 10'd2, 10'd28, 10'd29, 10'd30, 10'd56, 10'd57, 10'd58}};
    wv[1] = '{16'd1,   {10'd1, 10'd2, 10'd3, 10'd29, 10'd30, 10'd31, 10'd57, 10'd58, 10'd59}};
    wv[2] = '{16'd25,  {10'd25, 10'd26, 10'd27, 10'd53, 10'd54, 10'd55, 10'd81, 10'd82, 10'd83}};
    wv[3] = '{16'd26,  {10'd28, 10'd29, 10'd30, 10'd56, 10'd57, 10'd58, 10'd84, 10'd85, 10'd86}};
    wv[4] = '{16'd675, {10'd725, 10'd726, 10'd727, 10'd753, 10'd754, 10'd755, 10'd781, 10'd782, 10'd783}};

    step(3);
    rst = 1'b0;
    step(2);
    got_bits = int'({bus.ram_rd, bus.ram_addr, bus.pix_vld, bus.pix_first,
                     bus.pix_last, bus.busy, bus.frame_done});
    check("reset_outputs", got_bits, 0);
    $display("reset: outputs=%0d", got_bits);

    // ---- availability / core_bsy gating table ----
    for (int i = 0; i < 7; i++) begin
      restart(av[i].wr, av[i].bsy);
      lat = -1;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (bus.ram_rd && lat < 0) lat = c;
      end
      check("avail_latency", lat, av[i].exp_lat);
      $display("avail vec %0d: wr_addr=%0d core_bsy=%0d first_rd=%0d", i, av[i].wr, av[i].bsy, lat);
    end

    // ---- full frame, fixed inputs ----
    restart(NPIX, 1'b0);
    base_first = n_first; base_vld = n_vld; base_fd = n_fd;
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (bus.pix_vld) found = 1; else step(1);
    end
    check("gap_reach", found, 1);
    got_bits = 0; exp_bits = 0;
    for (int c = 0; c < 2 * (NTAP + 2); c++) begin
      got_bits = (got_bits << 1) | int'(bus.pix_vld);
      exp_bits = (exp_bits << 1) | int'((c % (NTAP + 2)) < NTAP);
      step(1);
    end
    check("vld_pattern", got_bits, exp_bits);
    $display("frame: pix_vld pattern=%0h", got_bits);
    found = 0;
    for (int c = 0; c < 20000 && !found; c++) begin
      if (bus.frame_done) found = 1; else step(1);
    end
    check("frame_done_reach", found, 1);
    base_rd = n_rd;
    step(30);
    check("done_no_reads", n_rd - base_rd, 0);
    check("done_busy", int'(bus.busy), 0);
    check("frame_firsts", n_first - base_first, NWIN);
    check("frame_vld", n_vld - base_vld, NWIN * NTAP);
    check("frame_done_count", n_fd - base_fd, 1);
    $display("frame: firsts=%0d vld=%0d frame_done=%0d", n_first - base_first,
             n_vld - base_vld, n_fd - base_fd);

    for (int i = 0; i < 5; i++) begin
      logic [NTAP*AW-1:0] a;
      a = wv[i].addrs;
      for (int t = 0; t < NTAP; t++)
        check("win_tap_addr", cap[int'(wv[i].win)][t], int'(a[(NTAP-1-t)*AW +: AW]));
      $display("window %0d: tl=%0d", int'(wv[i].win), cap[int'(wv[i].win)][0]);
    end

    // ---- core_bsy raised mid-window ----
    restart(NPIX, 1'b0);
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (bus.ram_rd) found = 1;
    end
    check("bsy_reach", found, 1);
    cnt = 1;
    repeat (3) begin @(posedge clk); #1; cnt += int'(bus.ram_rd); end
    bus.core_bsy = 1'b1;
    repeat (25) begin @(posedge clk); #1; cnt += int'(bus.ram_rd); end
    check("bsy_taps_complete", cnt, NTAP);
    bus.core_bsy = 1'b0;
    cnt = 0;
    repeat (5) begin @(posedge clk); #1; cnt += int'(bus.ram_rd); end
    check("bsy_resume", int'(cnt > 0), 1);
    $display("core_bsy at tap 3: window reads=%0d", NTAP);

    // ---- clr at tap 4 of window 10 ----
    restart(NPIX, 1'b0);
    cnt = 0; found = 0;
    for (int c = 0; c < 2000 && !found; c++) begin
      step(1);
      if (bus.ram_rd) begin
        if (cnt == 10 * NTAP + 4) found = 1;
        else cnt++;
      end
    end
    check("clr_reach", found, 1);
    check("clr_tap_addr", int'(bus.ram_addr), 10 + IMG_W + 1);
    bus.clr = 1'b1;
    step(1);
    check("clr_rd_next", int'(bus.ram_rd), 0);
    check("clr_vld_next", int'(bus.pix_vld), 0);
    bus.clr = 1'b0;
    step(1);
    check("clr_vld_after", int'(bus.pix_vld), 0);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (bus.ram_rd) found = 1; else step(1);
    end
    check("clr_restart_seen", found, 1);
    check("clr_restart_addr", int'(bus.ram_addr), 0);
    $display("clr at window 10 tap 4: restart addr=%0d", bus.ram_addr);

    // ---- asynchronous reset mid-ISSUE ----
    step(2);
    #2 rst = 1'b1;
    #1;
    got_bits = int'({bus.ram_rd, bus.ram_addr, bus.pix_vld, bus.pix_first,
                     bus.pix_last, bus.busy, bus.frame_done});
    check("async_rst_outputs", got_bits, 0);
    $display("rst mid-window: outputs=%0d", got_bits);
    step(2);
    rst = 1'b0;

    // ---- randomized frame: slow writer, random core_bsy ----
    restart(0, 1'b0);
    base_first = n_first; base_fd = n_fd;
    found = 0;
    begin
      int wr;
      wr = 0;
      for (int c = 0; c < 40000 && !found; c++) begin
        if ($urandom_range(0, 199) == 0 && wr > 20) wr -= int'($urandom_range(1, 20));
        else wr += int'($urandom_range(0, 3));
        if (wr > NPIX) wr = NPIX;
        bus.wr_addr  = AW'(wr);
        bus.core_bsy = ($urandom_range(0, 3) == 0);
        step(1);
        if (bus.frame_done) found = 1;
      end
    end
    check("rand_frame_done", found, 1);
    bus.core_bsy = 1'b0;
    step(3);
    check("rand_firsts", n_first - base_first, NWIN);
    check("rand_fd_count", n_fd - base_fd, 1);
    $display("random frame: firsts=%0d frame_done=%0d", n_first - base_first, n_fd - base_fd);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
